instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Datapath-side responder to the multicycle control FSM's fetch/PC controls. Owns the PC, the
//  instruction register (IR) and the instruction-memory request handshake. Feeds IR[31:26] back
//  to the FSM opcode input and resolves PC updates: sequential, conditional branch, absolute jump.
// PARAMETERS
//  PC_W      32  PC / instruction-address width in words; legal range 16..32
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk            in   1     system clock, rising edge
//  rst            in   1     asynchronous, active-low reset
//  InstMemRead    in   1     FSM: start an instruction fetch at the current PC
//  InstrRegWrite  in   1     FSM: load the fetched word into IR
//  PCWrite        in   1     FSM: unconditional PC update
//  PCWriteCond    in   1     FSM: conditional PC update (branch)
//  PCSource       in   2     FSM: 00 PC+1, 01 branch target, 10 jump target, 11 reserved
//  BranchType     in   1     FSM: 0 = BEQ (take if alu_zero), 1 = BNE (take if !alu_zero)
//  alu_zero       in   1     ALU zero flag, valid in the cycle PCWriteCond is asserted
//  imem_req       out  1     instruction memory request
//  imem_addr      out  PC_W  word address for the request; stable while imem_req=1
//  imem_ready     in   1     memory: imem_rdata valid this cycle
//  imem_rdata     in   32    instruction word from memory
//  instr          out  32    IR contents
//  opcode         out  6     IR[31:26], to FSM opcode input
//  pc             out  PC_W  current PC
//  fetch_stall    out  1     fetch outstanding, or IR load requested with no data available
//  pc_src_err     out  1     sticky flag: PC update attempted with PCSource=11
// BEHAVIOUR
//  Reset (async, rst=0): pc=RESET_PC; IR=0 (opcode=NOOP); state=IDLE; imem_req=0; imem_addr=0;
//   fetch_stall=0; pc_src_err=0; fetch buffer cleared. A reset during WAIT drops imem_req at once.
//  FSM states:
//   IDLE  : InstMemRead=1 -> imem_req=1, imem_addr<=pc, fpc<=pc, go WAIT.
//   WAIT  : imem_req held, imem_addr frozen. On imem_ready -> buf<=imem_rdata, go VALID.
//           If InstrRegWrite is also 1 that cycle, bypass: IR<=imem_rdata, ir_pc<=fpc, go IDLE.
//   VALID : InstrRegWrite=1 -> IR<=buf, ir_pc<=fpc, go IDLE. If InstMemRead=1 instead,
//           buf is discarded and a new fetch starts (same as IDLE). InstrRegWrite wins if both.
//  imem_ready while not in WAIT is ignored. InstMemRead while in WAIT is ignored; no second request.
//  fetch_stall = (state==WAIT) | (InstrRegWrite & state==IDLE). IR is unchanged while stalled.
//  Latency: zero-wait memory (imem_ready in the first WAIT cycle) gives IR valid 2 edges after
//   InstMemRead when InstrRegWrite arrives one cycle later.
//  PC update at the clock edge; takes effect when
//   PCWrite | (PCWriteCond & (BranchType ? ~alu_zero : alu_zero)).
//   PCWrite has priority, so PCWrite=1 ignores alu_zero.
//   Targets, all modulo 2^PC_W:
//    00 pc+1
//    01 ir_pc+1+sext(IR[15:0])
//    10 zero-extended IR[25:0], truncated to PC_W
//  PCSource=11 with a taken update: PC holds, pc_src_err<=1, cleared only by reset.
//  PC may update during WAIT; the outstanding request keeps its latched imem_addr.
//  pc+1 at all-ones wraps to 0. Branch arithmetic is two's complement, negative offsets allowed.
// TESTING
//  1 Reset with rst=0 mid-WAIT -> imem_req=0 immediately, pc=RESET_PC, opcode=0.
//    A later imem_ready is ignored.
//  2 pc=5, InstMemRead; ready after 3 cycles with 0xC8210005; then InstrRegWrite ->
//    imem_addr=5 throughout, fetch_stall=1 for 3 cycles, instr=0xC8210005, opcode=6'b110010.
//  3 IR=0x818D0001 fetched at pc=14, PCWriteCond, PCSource=01, BranchType=0, alu_zero=1 ->
//    pc=16. Repeat with alu_zero=0 -> pc unchanged.
//  4 BNE (BranchType=1) with IR offset 0xFFFF fetched at pc=20, alu_zero=0 -> pc=20.
//    PCWrite, PCSource=10, IR=0x04000000 -> pc=0.
//  5 pc=0xFFFFFFFF, PCWrite, PCSource=00 -> pc=0.
//    PCSource=11 with PCWrite -> pc holds, pc_src_err=1 and stays 1.
//  6 InstrRegWrite in the same cycle as imem_ready -> bypass load of IR, state IDLE next.
//    InstrRegWrite in IDLE -> fetch_stall=1, IR unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Owns the PC, the instruction register and the instruction-memory request
//   handshake for the multicycle control FSM. IR[31:26] is fed back to the
//   FSM as the opcode. PC updates: sequential, conditional branch, jump.
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   InstMemRead           start an instruction fetch at the current PC
//   InstrRegWrite         load the fetched word into IR
//   PCWrite, PCWriteCond  unconditional / conditional PC update
//   PCSource              00 PC+1, 01 branch target, 10 jump target, 11 reserved
//   BranchType, alu_zero  0 = BEQ, 1 = BNE; ALU zero flag for the branch decision
//   imem_req/imem_addr    request and latched word address to memory
//   imem_ready/imem_rdata memory response
//   instr, opcode, pc     IR, IR[31:26], current PC
//   fetch_stall           fetch outstanding, or IR load requested with no data
//   pc_src_err            sticky: taken PC update with PCSource=11
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            InstMemRead,
  input  logic            InstrRegWrite,
  input  logic            PCWrite,
  input  logic            PCWriteCond,
  input  logic [1:0]      PCSource,
  input  logic            BranchType,
  input  logic            alu_zero,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic [PC_W-1:0] pc,
  output logic            fetch_stall,
  output logic            pc_src_err
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

  state_t          state, stateNext;
  logic [31:0]     irReg, fetchBuf;
  logic [PC_W-1:0] pcReg, fetchPc, irPc, addrReg;
  logic            errReg;

  logic            startFetch, bufLoad, irLoadMem, irLoadBuf;
  logic            pcTaken;
  logic [31:0]     branchWide, jumpWide;
  logic [PC_W-1:0] pcNext;
  logic            pcUpdate, srcErr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // InstrRegWrite wins over InstMemRead in VALID; a new fetch from VALID drops the buffer.
  always_comb begin
    stateNext  = state;
    startFetch = 1'b0;
    bufLoad    = 1'b0;
    irLoadMem  = 1'b0;
    irLoadBuf  = 1'b0;
    unique case (state)
      IDLE: begin
        if (InstMemRead) begin
          startFetch = 1'b1;
          stateNext  = WAIT;
        end
      end
      WAIT: begin
        if (imem_ready) begin
          if (InstrRegWrite) begin
            irLoadMem = 1'b1;
            stateNext = IDLE;
          end else begin
            bufLoad   = 1'b1;
            stateNext = VALID;
          end
        end
      end
      VALID: begin
        if (InstrRegWrite) begin
          irLoadBuf = 1'b1;
          stateNext = IDLE;
        end else if (InstMemRead) begin
          startFetch = 1'b1;
          stateNext  = WAIT;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Targets are formed at 32 bits and truncated, which gives modulo-2^PC_W arithmetic.
  always_comb begin
    pcTaken    = PCWrite | (PCWriteCond & (BranchType ? ~alu_zero : alu_zero));
    branchWide = 32'(irPc) + 32'd1 + {{16{irReg[15]}}, irReg[15:0]};
    jumpWide   = {6'b0, irReg[25:0]};
    pcNext     = pcReg;
    pcUpdate   = 1'b0;
    srcErr     = 1'b0;
    if (pcTaken) begin
      unique case (PCSource)
        2'b00: begin pcNext = pcReg + 1'b1;            pcUpdate = 1'b1; end
        2'b01: begin pcNext = branchWide[PC_W-1:0];    pcUpdate = 1'b1; end
        2'b10: begin pcNext = jumpWide[PC_W-1:0];      pcUpdate = 1'b1; end
        default: srcErr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcReg    <= RESET_PC;
      irReg    <= '0;
      irPc     <= '0;
      fetchPc  <= '0;
      fetchBuf <= '0;
      addrReg  <= '0;
      errReg   <= 1'b0;
    end else begin
      if (pcUpdate) pcReg  <= pcNext;
      if (srcErr)   errReg <= 1'b1;
      if (startFetch) begin
        addrReg <= pcReg;
        fetchPc <= pcReg;
      end
      if (bufLoad) fetchBuf <= imem_rdata;
      if (irLoadMem) begin
        irReg <= imem_rdata;
        irPc  <= fetchPc;
      end else if (irLoadBuf) begin
        irReg <= fetchBuf;
        irPc  <= fetchPc;
      end
    end
  end

  assign imem_req    = (state == WAIT);
  assign imem_addr   = addrReg;
  assign instr       = irReg;
  assign opcode      = irReg[31:26];
  assign pc          = pcReg;
  assign fetch_stall = (state == WAIT) | (InstrRegWrite & (state == IDLE));
  assign pc_src_err  = errReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        InstMemRead = 1'b0, InstrRegWrite = 1'b0, PCWrite = 1'b0, PCWriteCond = 1'b0;
  logic [1:0]  PCSource = 2'b00;
  logic        BranchType = 1'b0, alu_zero = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic        fetch_stall, pc_src_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst),
    .InstMemRead(InstMemRead), .InstrRegWrite(InstrRegWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .BranchType(BranchType), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .pc(pc),
    .fetch_stall(fetch_stall), .pc_src_err(pc_src_err)
  );

  always #5 clk = ~clk;

  // Reference model: a fetch is either outstanding, buffered, or absent.
  logic [31:0] mPc, mIr, mIrPc, mFpc, mBuf, mAddr;
  bit          mOutstanding, mHaveBuf, mErr;

  task automatic mReset();
    mPc = 0; mIr = 0; mIrPc = 0; mFpc = 0; mBuf = 0; mAddr = 0;
    mOutstanding = 0; mHaveBuf = 0; mErr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    bit expStall;
    expStall = mOutstanding || (InstrRegWrite && !mOutstanding && !mHaveBuf);
    chk("imem_req", {31'b0, imem_req}, {31'b0, mOutstanding});
    chk("imem_addr", imem_addr, mAddr);
    chk("instr", instr, mIr);
    chk("opcode", {26'b0, opcode}, {26'b0, mIr[31:26]});
    chk("pc", pc, mPc);
    chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, expStall});
    chk("pc_src_err", {31'b0, pc_src_err}, {31'b0, mErr});
  endtask

  task automatic mEdge();
    logic [31:0] oldPc;
    bit taken;
    oldPc = mPc;
    taken = PCWrite || (PCWriteCond && (BranchType ? !alu_zero : alu_zero));
    if (taken) begin
      case (PCSource)
        2'd0: mPc = oldPc + 1;
        2'd1: mPc = mIrPc + 1 + {{16{mIr[15]}}, mIr[15:0]};
        2'd2: mPc = {6'b0, mIr[25:0]};
        default: mErr = 1;
      endcase
    end
    if (mOutstanding) begin
      if (imem_ready) begin
        mOutstanding = 0;
        if (InstrRegWrite) begin mIr = imem_rdata; mIrPc = mFpc; end
        else begin mBuf = imem_rdata; mHaveBuf = 1; end
      end
    end else if (mHaveBuf && InstrRegWrite) begin
      mIr = mBuf; mIrPc = mFpc; mHaveBuf = 0;
    end else if (InstMemRead) begin
      mOutstanding = 1; mHaveBuf = 0; mAddr = oldPc; mFpc = oldPc;
    end
  endtask

  task automatic step(input bit imr, input bit irw, input bit pcw, input bit pcwc,
                      input logic [1:0] src, input bit bt, input bit z,
                      input bit rdy, input logic [31:0] rd);
    @(negedge clk);
    InstMemRead = imr; InstrRegWrite = irw; PCWrite = pcw; PCWriteCond = pcwc;
    PCSource = src; BranchType = bt; alu_zero = z; imem_ready = rdy; imem_rdata = rd;
    #1 checkAll();
    @(posedge clk);
    mEdge();
  endtask

  task automatic incPc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0);
  endtask

  task automatic fetchWord(input logic [31:0] w);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1, w);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0);
  endtask

  initial begin
    mReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 checkAll();

    // Reset in the middle of an outstanding fetch
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0);
    @(negedge clk);
    PCWrite = 0; #2 rst = 1'b0;
    #1;
    mReset();
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_opcode", {26'b0, opcode}, 32'd0);
    @(negedge clk) rst = 1'b1;
    step(0, 0, 0, 0, 2'b00, 0, 0, 1, 32'hDEADBEEF);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("ready_ignored", instr, 32'h0);

    // Fetch at pc=5 with three wait cycles
    incPc(5);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 1, 32'hC8210005);
    step(0, 1, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t2_instr", instr, 32'hC8210005);
    chk("t2_opcode", {26'b0, opcode}, 32'b110010);
    chk("t2_addr", imem_addr, 32'd5);

    // BEQ taken / not taken
    incPc(9);
    fetchWord(32'h818D0001);
    step(0, 0, 0, 1, 2'b01, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 2'b01, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t3_pc", pc, 32'd16);

    // BNE with offset -1, then jump
    incPc(4);
    fetchWord(32'h0000FFFF);
    step(0, 0, 0, 1, 2'b01, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t4_bne_pc", pc, 32'd20);
    fetchWord(32'h04000000);
    step(0, 0, 1, 0, 2'b10, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t4_jump_pc", pc, 32'd0);

    // Reach all-ones via a negative branch, wrap, then reserved source
    fetchWord(32'h0000FFFE);
    step(0, 0, 1, 0, 2'b01, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t5_allones", pc, 32'hFFFFFFFF);
    step(0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t5_wrap", pc, 32'd0);
    step(0, 0, 1, 0, 2'b11, 0, 0, 0, 32'h0);
    incPc(2);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t5_err_sticky", {31'b0, pc_src_err}, 32'd1);

    // Same-cycle bypass, then IR load requested in IDLE
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 2'b00, 0, 0, 1, 32'h12345678);
    step(0, 1, 0, 0, 2'b00, 0, 0, 1, 32'h9ABCDEF0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    chk("t6_bypass", instr, 32'h12345678);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, $urandom);
    end
    @(negedge clk);
    #1 checkAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
